glip_jtag_master: RTL and testbench

//  Host-side JTAG master: the driving end of the GLIP JTAG link. Generates
//  tck/tms/tdi from the system clock and samples tdo from the target TAP.

---
 rtl/glip_jtag_master.sv | 136 +++++++++++++
 tb/tb_glip_jtag_master.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glip_jtag_master.sv
// glip_jtag_master: host-side JTAG master that runs one complete IR or DR scan per request
// and returns the tdo bits captured during the shift.
module glip_jtag_master #(
  parameter int MAX_BITS  = 80,
  parameter int LEN_WIDTH = 7,
  parameter int CLK_DIV   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_ir,
  input  logic [LEN_WIDTH-1:0] req_len,
  input  logic [MAX_BITS-1:0]  req_data,
  input  logic                 tap_reset,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [MAX_BITS-1:0]  resp_data,
  output logic                 busy,
  output logic                 tck,
  output logic                 tms,
  output logic                 tdi,
  input  logic                 tdo
);
  localparam int KW = (LEN_WIDTH > $clog2(MAX_BITS + 8)) ? LEN_WIDTH : $clog2(MAX_BITS + 8);
  localparam int IW = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
  localparam int CW = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  typedef enum logic [1:0] {TLR, IDLE, SCAN, RESP} state_e;
  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [KW-1:0]       k_q, k_d, len_q, len_d;
  logic                ir_q, ir_d, tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic [MAX_BITS-1:0] data_q, data_d, resp_q, resp_d;
  logic [KW-1:0]       n_last, s0, k_nx;
  logic [IW-1:0]       i_cur, i_nx;
  logic                rise, step_end, sh_cur, sh_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TLR;
      cnt_q   <= '0;
      k_q     <= '0;
      len_q   <= '0;
      ir_q    <= 1'b0;
      data_q  <= '0;
      resp_q  <= '0;
      tck_q   <= 1'b0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      len_q   <= len_d;
      ir_q    <= ir_d;
      data_q  <= data_d;
      resp_q  <= resp_d;
      tck_q   <= tck_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
    end
  end
  // k counts steps of the whole scan; shift steps start at s0 and the scan ends at n_last
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    len_d    = len_q;
    ir_d     = ir_q;
    data_d   = data_q;
    resp_d   = resp_q;
    tck_d    = tck_q;
    tms_d    = tms_q;
    tdi_d    = tdi_q;
    n_last   = len_q + (ir_q ? KW'(5) : KW'(4));
    s0       = ir_q ? KW'(4) : KW'(3);
    k_nx     = k_q + KW'(1);
    rise     = cnt_q == CW'(CLK_DIV - 1);
    step_end = cnt_q == CW'(2 * CLK_DIV - 1);
    sh_cur   = k_q >= s0 && k_q < s0 + len_q;
    sh_nx    = k_nx >= s0 && k_nx < s0 + len_q;
    i_cur    = IW'(k_q - s0);
    i_nx     = IW'(k_nx - s0);
    case (state_q)
      TLR, SCAN: begin
        cnt_d = step_end ? '0 : cnt_q + CW'(1);
        if (rise) tck_d = 1'b1;
        if (rise && state_q == SCAN && sh_cur) resp_d[i_cur] = tdo;
        if (step_end) begin
          tck_d = 1'b0;
          k_d   = k_nx;
          if (state_q == TLR) begin
            tms_d = k_q != KW'(4);
            if (k_q == KW'(5)) begin
              state_d = IDLE;
              tms_d   = 1'b0;
              k_d     = '0;
            end
          end else if (k_q == n_last) begin
            state_d = RESP;
            tms_d   = 1'b0;
            tdi_d   = 1'b0;
            k_d     = '0;
          end else begin
            tms_d = (ir_q && k_nx == KW'(1)) || k_nx == n_last - KW'(1) || k_nx == n_last - KW'(2);
            tdi_d = sh_nx && data_q[i_nx];
          end
        end
      end
      IDLE: begin
        cnt_d = '0;
        k_d   = '0;
        if (tap_reset) begin
          state_d = TLR;
          tms_d   = 1'b1;
        end else if (req_valid) begin
          state_d = SCAN;
          tms_d   = 1'b1;
          ir_d    = req_ir;
          len_d   = KW'(req_len) > KW'(MAX_BITS) ? KW'(MAX_BITS) : KW'(req_len);
          data_d  = req_data;
          resp_d  = '0;
        end
      end
      default: if (resp_ready) state_d = IDLE;
    endcase
  end
  always_comb begin
    req_ready  = state_q == IDLE && !tap_reset;
    resp_valid = state_q == RESP;
    busy       = state_q != IDLE;
    resp_data  = resp_q;
    tck        = tck_q;
    tms        = tms_q;
    tdi        = tdi_q;
  end
endmodule

// File: tb/tb_glip_jtag_master.sv
// tb_glip_jtag_master: drives scans into the master against a behavioural TAP with an
// 8-bit DR and 4-bit IR, scoreboarding the captured data and checking tms/tdi sequences.
module tb_glip_jtag_master;
  localparam int MB = 80;
  logic          clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, req_ir = 1'b0;
  logic          tap_reset = 1'b0, resp_ready = 1'b0, tdo = 1'b0;
  logic [6:0]    req_len = '0;
  logic [MB-1:0] req_data = '0;
  logic          req_ready, resp_valid, busy, tck, tms, tdi;
  logic [MB-1:0] resp_data;
  int            n_tests = 0, n_fail = 0;
  logic [MB-1:0] exp_q[$];

  glip_jtag_master #(.MAX_BITS(MB), .LEN_WIDTH(7), .CLK_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_ir(req_ir), .req_len(req_len), .req_data(req_data), .tap_reset(tap_reset),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .busy(busy),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  always #5 clk = ~clk;

  // TAP model: 0 TLR 1 RTI 2 SelDR 3 CapDR 4 ShDR 5 Ex1DR 6 PauDR 7 Ex2DR 8 UpdDR, 9..15 IR side
  int         ts = 0, n_tck = 0;
  logic [7:0] dr = 8'h3C, dsr = '0;
  logic [3:0] ir = 4'h1, isr = '0;
  logic       tms_log [1024];
  logic       tdi_log [1024];

  function automatic int tap_next(int s, logic m);
    case (s)
      0:       return m ? 0 : 1;
      1:       return m ? 2 : 1;
      2:       return m ? 9 : 3;
      3, 4:    return m ? 5 : 4;
      5:       return m ? 8 : 6;
      6:       return m ? 7 : 6;
      7:       return m ? 8 : 4;
      8, 15:   return m ? 2 : 1;
      9:       return m ? 0 : 10;
      10, 11:  return m ? 12 : 11;
      12:      return m ? 15 : 13;
      13:      return m ? 14 : 13;
      14:      return m ? 15 : 11;
      default: return 0;
    endcase
  endfunction

  always @(posedge tck) begin
    if (n_tck < 1024) begin
      tms_log[n_tck] <= tms;
      tdi_log[n_tck] <= tdi;
    end
    n_tck <= n_tck + 1;
    case (ts)
      3:       dsr <= dr;
      4:       dsr <= {tdi, dsr[7:1]};
      8:       dr <= dsr;
      10:      isr <= ir;
      11:      isr <= {tdi, isr[3:1]};
      15:      ir <= isr;
      default: ;
    endcase
    ts <= tap_next(ts, tms);
  end

  always @(negedge tck) tdo <= ts == 4 ? dsr[0] : ts == 11 ? isr[0] : 1'b0;

  function automatic logic [127:0] gather(bit sel_tdi, int base, int n);
    logic [127:0] v = '0;
    for (int j = 0; j < n; j++) v[j] = sel_tdi ? tdi_log[base + j] : tms_log[base + j];
    return v;
  endfunction

  // expected capture of a w-bit TAP register chain: tdo = register bit 0, tdi enters at the top
  task automatic model_scan(input logic [MB-1:0] d, input int l, input logic [7:0] init,
                            input int w, output logic [MB-1:0] r, output logic [7:0] nr);
    logic [7:0] sr = init;
    r = '0;
    for (int i = 0; i < l; i++) begin
      r[i] = sr[0];
      sr   = (sr >> 1) | (8'(d[i]) << (w - 1));
    end
    nr = sr;
  endtask

  task automatic wait_ready();
    int c = 0;
    while (!req_ready && c < 500) begin
      @(negedge clk);
      c++;
    end
    if (!req_ready) begin
      n_fail++;
      $display("FAIL wait_ready: req_ready=%b required 1 within 500 cycles", req_ready);
    end
  endtask

  task automatic run_scan(input logic ir_s, input int len, input logic [MB-1:0] d,
                          output int lat, output int base, output logic [7:0] nr);
    logic [MB-1:0] r;
    int l = len > MB ? MB : len;
    wait_ready();
    model_scan(d, l, ir_s ? {4'h0, ir} : dr, ir_s ? 4 : 8, r, nr);
    exp_q.push_back(r);
    base      = n_tck;
    req_valid = 1'b1;
    req_ir    = ir_s;
    req_len   = 7'(len);
    req_data  = d;
    @(posedge clk);
    lat = 0;
    while (lat < 2000) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (resp_valid) break;
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic check_resp(string name);
    logic [MB-1:0] e = exp_q.pop_front();
    n_tests++;
    if (resp_data !== e) begin
      n_fail++;
      $display("FAIL %s resp_data: got %h required %h", name, resp_data, e);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if ({tck, tms, tdi, req_ready, resp_valid, busy} !== 6'b010001 || resp_data !== '0) begin
      n_fail++;
      $display("FAIL reset_state: tck/tms/tdi/rdy/rv/busy=%b resp=%h required 010001 0",
               {tck, tms, tdi, req_ready, resp_valid, busy}, resp_data);
    end
    rst_n = 1'b1;
    wait_ready();
    n_tests++;
    if (n_tck !== 6 || gather(0, 0, 6) !== 128'h1F) begin
      n_fail++;
      $display("FAIL reset_tlr: pulses=%0d tms=%h required 6 1f", n_tck, gather(0, 0, 6));
    end
    n_tests++;
    if (tck !== 1'b0 || ts !== 1) begin
      n_fail++;
      $display("FAIL reset_idle: tck=%b tap_state=%0d required 0 1", tck, ts);
    end
  endtask

  task automatic test_dr_scan();
    int lat, base;
    logic [7:0] nr;
    run_scan(1'b0, 8, 80'hA5, lat, base, nr);
    check_resp("dr_scan");
    n_tests++;
    if (resp_data !== 80'h3C) begin
      n_fail++;
      $display("FAIL dr_capture: got %h required 3c", resp_data);
    end
    n_tests++;
    if (lat !== 52) begin
      n_fail++;
      $display("FAIL dr_latency: got %0d required 52", lat);
    end
    n_tests++;
    if (n_tck - base !== 13 || gather(0, base, 13) !== 128'hC01) begin
      n_fail++;
      $display("FAIL dr_tms: steps=%0d tms=%h required 13 c01", n_tck - base, gather(0, base, 13));
    end
    n_tests++;
    if (gather(1, base + 3, 8) !== 128'hA5) begin
      n_fail++;
      $display("FAIL dr_tdi: got %h required a5", gather(1, base + 3, 8));
    end
    n_tests++;
    if (dr !== 8'hA5 || dr !== nr) begin
      n_fail++;
      $display("FAIL dr_update: tap dr=%h required a5", dr);
    end
    consume();
  endtask

  task automatic test_ir_scan();
    int lat, base;
    logic [7:0] nr;
    run_scan(1'b1, 4, 80'h8, lat, base, nr);
    check_resp("ir_scan");
    n_tests++;
    if (lat !== 40 || n_tck - base !== 10 || gather(0, base, 10) !== 128'h183) begin
      n_fail++;
      $display("FAIL ir_tms: lat=%0d steps=%0d tms=%h required 40 10 183",
               lat, n_tck - base, gather(0, base, 10));
    end
    n_tests++;
    if (ir !== 4'h8) begin
      n_fail++;
      $display("FAIL ir_update: tap ir=%h required 8", ir);
    end
    consume();
  endtask

  task automatic test_backpressure();
    int lat, base;
    logic [7:0] nr;
    logic [MB-1:0] snap;
    run_scan(1'b0, 8, 80'h96, lat, base, nr);
    check_resp("bp_scan");
    snap = resp_data;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_tests++;
      if (resp_valid !== 1'b1 || resp_data !== snap || tck !== 1'b0 || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: rv=%b data=%h tck=%b rdy=%b required 1 %h 0 0",
                 c, resp_valid, resp_data, tck, req_ready, snap);
      end
    end
    consume();
    n_tests++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: rv=%b rdy=%b required 0 1", resp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    int lat, base, c;
    logic [7:0] nr;
    wait_ready();
    base      = n_tck;
    req_valid = 1'b1;
    req_ir    = 1'b0;
    req_len   = 7'd8;
    req_data  = 80'hFF;
    @(negedge clk);
    req_valid = 1'b0;
    for (c = 0; c < 200 && n_tck < base + 7; c++) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (tck !== 1'b0 || tms !== 1'b1 || busy !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: tck=%b tms=%b busy=%b rv=%b required 0 1 1 0",
               tck, tms, busy, resp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    base = n_tck;
    wait_ready();
    n_tests++;
    if (n_tck - base !== 6 || gather(0, base, 6) !== 128'h1F || ts !== 1) begin
      n_fail++;
      $display("FAIL mid_tlr: pulses=%0d tms=%h tap=%0d required 6 1f 1",
               n_tck - base, gather(0, base, 6), ts);
    end
    run_scan(1'b0, 8, 80'h5A, lat, base, nr);
    check_resp("mid_rescan");
    n_tests++;
    if (lat !== 52 || dr !== 8'h5A) begin
      n_fail++;
      $display("FAIL mid_rescan: lat=%0d dr=%h required 52 5a", lat, dr);
    end
    consume();
  endtask

  task automatic test_length();
    int lat, base;
    logic [7:0] nr;
    logic [MB-1:0] d = {16'($urandom), $urandom, $urandom};
    run_scan(1'b0, 100, d, lat, base, nr);
    check_resp("len_clamp");
    n_tests++;
    if (n_tck - base !== 85 || lat !== 340 || gather(1, base + 3, 80) !== 128'(d)) begin
      n_fail++;
      $display("FAIL len_clamp: steps=%0d lat=%0d tdi=%h required 85 340 %h",
               n_tck - base, lat, gather(1, base + 3, 80), d);
    end
    consume();
    run_scan(1'b0, 0, 80'hFFFF, lat, base, nr);
    check_resp("len_zero");
    n_tests++;
    if (n_tck - base !== 5 || gather(0, base, 5) !== 128'hD || resp_data !== '0) begin
      n_fail++;
      $display("FAIL len_zero: steps=%0d tms=%h resp=%h required 5 d 0",
               n_tck - base, gather(0, base, 5), resp_data);
    end
    consume();
  endtask

  task automatic test_tap_reset();
    int base, c;
    logic [7:0] nr;
    logic [MB-1:0] r;
    wait_ready();
    base = n_tck;
    model_scan(80'hC3, 8, dr, 8, r, nr);
    exp_q.push_back(r);
    tap_reset = 1'b1;
    req_valid = 1'b1;
    req_ir    = 1'b0;
    req_len   = 7'd8;
    req_data  = 80'hC3;
    #1;
    n_tests++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL tap_reset_ready: got %b required 0", req_ready);
    end
    @(negedge clk);
    tap_reset = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || tms !== 1'b1) begin
      n_fail++;
      $display("FAIL tap_reset_tlr: busy=%b tms=%b required 1 1", busy, tms);
    end
    wait_ready();
    @(negedge clk);
    req_valid = 1'b0;
    for (c = 0; c < 500 && !resp_valid; c++) @(negedge clk);
    check_resp("tap_reset_scan");
    n_tests++;
    if (n_tck - base !== 19 || gather(0, base, 19) !== 128'h3005F || dr !== 8'hC3) begin
      n_fail++;
      $display("FAIL tap_reset_seq: steps=%0d tms=%h dr=%h required 19 3005f c3",
               n_tck - base, gather(0, base, 19), dr);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_dr_scan();
    test_ir_scan();
    test_backpressure();
    test_reset_mid();
    test_length();
    test_tap_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
